// File: rtl/mdio_receptor.sv
// mdio_receptor: PHY-side Clause-22 MDIO frame deserializer driving a 32x16 register file.
// Build option MDIO_PHYADDR_FILTER_EN: frames for another PHYADDR are counted out silently.
module mdio_receptor #(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    input  logic [15:0] RD_DATA,
    output logic        MDIO_IN,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_REQ,
    output logic        FRAME_ERR,
    output logic        BUSY
);
    typedef enum logic [2:0] {IDLE, HEADER, WRITE, READ, IGNORE} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [14:0] sr_q, sr_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [4:0]  addr_q, addr_d;
    logic        mdc_q, rd_cap_q;
    logic        mdio_in_q, mdio_in_d;
    logic        wr_stb_q, wr_stb_d;
    logic        rd_req_q, rd_req_d;
    logic        ferr_q, ferr_d;

    logic        rise, fall, hdr_ok, addr_match;
    logic [15:0] sr_sh;
    logic [5:0]  cnt_inc;

    assign rise    = MDC & ~mdc_q;
    assign fall    = ~MDC & mdc_q;
    assign sr_sh   = {sr_q, MDIO_OUT};
    assign cnt_inc = cnt_q + 6'd1;
    // sr_sh[13:0] holds ST,OP,PHYADDR,REGADDR on the 14th rise
    assign hdr_ok  = (sr_sh[13:12] == 2'b01) &&
                     ((sr_sh[11:10] == 2'b01) || (sr_sh[11:10] == 2'b10));

`ifdef MDIO_PHYADDR_FILTER_EN
    assign addr_match = (sr_sh[9:5] == PHY_ADDR);
`else
    logic unused_phy_addr;
    assign unused_phy_addr = ^PHY_ADDR;
    assign addr_match      = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            tx_q      <= '0;
            wr_data_q <= '0;
            addr_q    <= '0;
            mdc_q     <= 1'b0;
            rd_cap_q  <= 1'b0;
            mdio_in_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            tx_q      <= tx_d;
            wr_data_q <= wr_data_d;
            addr_q    <= addr_d;
            mdc_q     <= MDC;
            rd_cap_q  <= rd_req_q;
            mdio_in_q <= mdio_in_d;
            wr_stb_q  <= wr_stb_d;
            rd_req_q  <= rd_req_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        tx_d      = tx_q;
        wr_data_d = wr_data_q;
        addr_d    = addr_q;
        mdio_in_d = mdio_in_q;
        wr_stb_d  = 1'b0;
        rd_req_d  = 1'b0;
        ferr_d    = 1'b0;
        // memory answers one clk after RD_REQ
        if (rd_cap_q) tx_d = RD_DATA;
        case (state_q)
            IDLE: if (rise && MDIO_OE) begin
                sr_d    = sr_sh[14:0];
                cnt_d   = 6'd1;
                state_d = HEADER;
            end
            HEADER: if (rise) begin
                if (!MDIO_OE) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    sr_d  = sr_sh[14:0];
                    cnt_d = cnt_inc;
                    if (cnt_inc == 6'd14) begin
                        if (!hdr_ok) begin
                            ferr_d  = 1'b1;
                            state_d = IDLE;
                        end else if (!addr_match) begin
                            state_d = IGNORE;
                        end else begin
                            addr_d = sr_sh[4:0];
                            if (sr_sh[11:10] == 2'b01) begin
                                state_d = WRITE;
                            end else begin
                                rd_req_d = 1'b1;
                                state_d  = READ;
                            end
                        end
                    end
                end
            end
            WRITE: if (rise) begin
                if (!MDIO_OE) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    sr_d  = sr_sh[14:0];
                    cnt_d = cnt_inc;
                    if (cnt_inc == 6'd32) begin
                        wr_data_d = sr_sh;
                        wr_stb_d  = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            READ: begin
                if (rise) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 6'd32) begin
                        mdio_in_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else if (fall && cnt_q >= 6'd16) begin
                    // first data bit goes out on the fall after the second TA rise
                    mdio_in_d = tx_q[15];
                    tx_d      = {tx_q[14:0], 1'b0};
                end
            end
            IGNORE: if (rise) begin
                cnt_d = cnt_inc;
                if (cnt_inc == 6'd32) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign MDIO_IN   = mdio_in_q;
    assign ADDR      = addr_q;
    assign WR_DATA   = wr_data_q;
    assign WR_STB    = wr_stb_q;
    assign RD_REQ    = rd_req_q;
    assign FRAME_ERR = ferr_q;
    assign BUSY      = (state_q != IDLE);
endmodule
